io_device2: RTL and testbench
=============================

Name: io_device2

Overview:
- Second peripheral on the DMA I/O bus. It buffers 32-bit words in an internal FIFO and exchanges them with the bus master over one shared bidirectional data bus.
- A single direction line selects whether the device samples the bus (push) or drives it (pop).
- GPIO1 is the device's data-ready/interrupt line toward the DMA controller. It is high whenever the buffer holds at least one word.

Parameters:
- DATA_W, 32, bus and buffer word width.
- DEPTH, 32, buffer depth in words (power of two).
- PTR_W, 5, log2(DEPTH); pointer width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- IOWrite1  input  1  direction. 1 = device drives Data (pop to bus); 0 = master drives Data (push into device).
- Data  inout  DATA_W  shared data bus.
- GPIO1  output  1  data-ready/interrupt. 1 while the buffer is non-empty.

Behaviour:
- Internal state:
  - mem[DEPTH] of DATA_W bits.
  - wr_ptr and rd_ptr, PTR_W bits each.
  - count, PTR_W+1 bits, range 0..DEPTH.
  - OData output register, DATA_W bits.
  - GPIO1 register.
- Reset (rst=1, asynchronous, overrides clock):
  - wr_ptr=0, rd_ptr=0, count=0, OData=0, GPIO1=0.
  - mem contents are not cleared.
  - While rst=1, Data is high-Z regardless of IOWrite1.
- Bus drive (combinational):
  - Data = OData when IOWrite1==1 and rst==0; otherwise all-Z.
  - When IOWrite1 is not exactly 1, the device never drives the bus.
- Push cycle (rising edge with IOWrite1==0):
  - If count<DEPTH: mem[wr_ptr] <= Data; wr_ptr <= wr_ptr+1 (wraps modulo DEPTH); count <= count+1.
  - If count==DEPTH (full): the word is discarded and no state changes.
  - OData is unchanged.
- Pop cycle (rising edge with IOWrite1==1):
  - If count>0: OData <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps); count <= count-1.
  - If count==0 (empty): OData holds its previous value and the pointers are unchanged.
- Latency:
  - A popped word appears on Data immediately after the rising edge that pops it.
  - In the first IOWrite1==1 cycle, before any edge, Data shows the stale OData.
  - A pushed word is poppable from the next edge onward.
- GPIO1 is registered: GPIO1 <= (next count != 0).
  - It rises on the edge that pushes into an empty buffer.
  - It falls on the edge that pops the last word.
- Push and pop cannot occur in the same cycle, because IOWrite1 selects exactly one.
- Ordering is strict FIFO, including across pointer wrap-around.
- If IOWrite1 is X/Z at an edge, no push and no pop take place and Data is high-Z.

Test Plan:
- Reset: assert rst mid-clock with IOWrite1=1 -> Data=Z immediately, GPIO1=0, count=0; after release with IOWrite1=1 and empty buffer -> Data=0.
- Push/interrupt: IOWrite1=0, drive 1,0,1,0,1 on five consecutive edges -> GPIO1=1 after the first edge, count=5, Data not driven by the device.
- Pop order: then IOWrite1=1 for six edges -> Data=1,0,1,0,1 after edges 1..5; GPIO1 falls after edge 5; after edge 6 Data still 1 (empty pop holds OData).
- Direction turnaround: IOWrite1=1 -> 0 -> 1 with master driving 32'h1 while IOWrite1=0 -> device releases the bus within the same cycle; one word (1) is pushed; the next pop yields 1.
- Full: push 33 words 0..32 -> count=32, word 32 discarded, GPIO1=1; 32 pops return 0..31 in order, then GPIO1=0.
- Wrap-around: push 20, pop 20, push 20 (values 100..119), pop 20 -> values returned 100..119 in order across the pointer wrap.

Source files
------------

// File: rtl/io_device2.sv
// FIFO-buffered peripheral on a shared bidirectional bus: pushes when IOWrite1=0,
// pops onto the bus when IOWrite1=1; GPIO1 flags a non-empty buffer.
module io_device2 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PTR_W  = 5
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              IOWrite1,
  inout  wire  [DATA_W-1:0] Data,
  output logic              GPIO1
);

  localparam logic [PTR_W:0] CountFull = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              gpio1_q, gpio1_d;

  logic dir_push, dir_pop;
  logic push, pop;

  // Case-equality keeps an X/Z direction from being treated as either push or pop.
  assign dir_push = (IOWrite1 === 1'b0);
  assign dir_pop  = (IOWrite1 === 1'b1);

  assign push = dir_push && (count_q != CountFull);
  assign pop  = dir_pop && (count_q != '0);

  assign Data  = (dir_pop && !rst) ? odata_q : {DATA_W{1'bz}};
  assign GPIO1 = gpio1_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    odata_d  = odata_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (pop) begin
      odata_d  = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
    gpio1_d = (count_d != '0);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      odata_q  <= '0;
      gpio1_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      odata_q  <= odata_d;
      gpio1_q  <= gpio1_d;
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= Data;
    end
  end

endmodule

// File: tb/tb_io_device2.sv
// Bench for io_device2: directed scenarios plus random push/pop traffic, checked
// against a queue-based FIFO model.
module tb_io_device2;

  localparam int unsigned Depth = 32;

  logic        clock = 1'b0;
  logic        rst;
  logic        iowrite;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] data;
  wire         gpio1;

  assign data = drv_en ? drv_val : 'z;

  always #5 clock = ~clock;

  io_device2 #(
    .DATA_W(32),
    .DEPTH (32),
    .PTR_W (5)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .IOWrite1(iowrite),
    .Data    (data),
    .GPIO1   (gpio1)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the buffer is a plain queue, last_out is the word on the bus.
  logic [31:0] model_q[$];
  logic [31:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic dir, input logic [31:0] val, input string tag);
    @(negedge clock);
    iowrite = dir;
    drv_en  = ~dir;
    drv_val = val;
    #1;
    if (dir) check({tag, "_pre"}, data, last_out);
    @(posedge clock);
    #1;
    if (!dir) begin
      if (model_q.size() < Depth) model_q.push_back(val);
    end else if (model_q.size() > 0) begin
      last_out = model_q.pop_front();
    end
    check({tag, "_gpio"}, {31'd0, gpio1}, {31'd0, model_q.size() != 0});
    if (dir) check({tag, "_data"}, data, last_out);
    else     check({tag, "_bus"}, data, val);
  endtask

  initial begin
    rst      = 1'b1;
    iowrite  = 1'b1;
    drv_en   = 1'b0;
    drv_val  = '0;
    last_out = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check("reset_data", data, 32'd0);
    check("reset_gpio", {31'd0, gpio1}, 32'd0);
    step(1'b1, '0, "empty_pop0");

    // Push 1,0,1,0,1 then pop six times; the sixth pop hits an empty buffer.
    for (int i = 0; i < 5; i++) step(1'b0, 32'(((i + 1) % 2)), "push_alt");
    for (int i = 0; i < 6; i++) step(1'b1, '0, "pop_alt");

    // Turnaround: pop, push 1, pop it back.
    step(1'b1, '0, "turn_pop");
    step(1'b0, 32'h1, "turn_push");
    step(1'b1, '0, "turn_pop2");

    // Overfill with 0..32; the 33rd word must be dropped.
    for (int i = 0; i <= 32; i++) step(1'b0, 32'(i), "full_push");
    for (int i = 0; i < 33; i++) step(1'b1, '0, "full_pop");

    // Cross the pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b0, 32'(i + 500), "wrap_fill");
    for (int i = 0; i < 20; i++) step(1'b1, '0, "wrap_drain");
    for (int i = 0; i < 20; i++) step(1'b0, 32'(i + 100), "wrap_push");
    for (int i = 0; i < 20; i++) step(1'b1, '0, "wrap_pop");

    // Random traffic, biased toward pushes so the full boundary is visited.
    for (int i = 0; i < 400; i++) begin
      if (i < 200) step(($urandom_range(0, 9) < 4), $urandom, "rand_a");
      else         step(($urandom_range(0, 9) < 6), $urandom, "rand_b");
    end

    // Asynchronous reset mid-cycle with words buffered and the device driving.
    for (int i = 0; i < 3; i++) step(1'b0, 32'(i + 7), "pre_rst_push");
    step(1'b1, '0, "pre_rst_pop");
    @(posedge clock);
    #2;
    iowrite = 1'b1;
    drv_en  = 1'b0;
    rst     = 1'b1;
    #1;
    check("mid_rst_gpio", {31'd0, gpio1}, 32'd0);
    @(negedge clock);
    rst = 1'b0;
    model_q.delete();
    last_out = '0;
    #1;
    check("post_rst_data", data, 32'd0);
    step(1'b1, '0, "post_rst_pop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
